// File: rtl/obi_spiflash_responder.sv
// OBI responder for the flash window: turns OBI word reads into SPI READ (0x03)
// frames to an external serial NOR flash; writes are refused and flagged illegal.

module obi_spiflash_responder #(
    parameter logic [31:0] FLASH_BASE_ADDR = 32'h2000_0000,
    parameter int          ADDR_WIDTH      = 24,
    parameter int          CLK_DIV         = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flash_req_i,
    output logic        flash_gnt_o,
    input  logic [31:0] flash_addr_i,
    input  logic        flash_we_i,
    input  logic [3:0]  flash_be_i,
    input  logic [31:0] flash_wdata_i,
    output logic        flash_rvalid_o,
    output logic [31:0] flash_rdata_o,
    output logic        spi_sck_o,
    output logic        spi_csb_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic        busy_o,
    output logic        illegal_write_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // GAP is one cycle shorter than 2*CLK_DIV so the next grant lands exactly
    // 2*CLK_DIV cycles after rvalid; DONE and IDLE keep CSB high around it.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 2);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE, GAP} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [5:0]        bit_cnt_q;
    logic              sck_q;
    logic              is_write_q;
    logic [31:0]       tx_q;
    logic [31:0]       rx_q;
    logic [31:0]       rdata_q;

    logic [31:0]       flash_offset;
    logic [23:0]       frame_addr;
    logic [31:0]       rx_next;
    logic              accept;
    logic              shifting;
    logic              div_last;
    logic              period_end;
    logic              sample;
    logic              unused_inputs;

    assign accept     = flash_req_i && (state_q == IDLE);
    assign shifting   = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    assign div_last   = (div_cnt_q == DIV_LAST);
    assign period_end = shifting && sck_q && div_last;
    assign sample     = (state_q == DATA) && sck_q && div_last;
    assign rx_next    = {rx_q[30:0], spi_miso_i};

    always_comb begin
        flash_offset = flash_addr_i - FLASH_BASE_ADDR;
        frame_addr = '0;
        frame_addr[ADDR_WIDTH-1:0] = flash_offset[ADDR_WIDTH-1:0];
        frame_addr[1:0] = 2'b00;
    end

    assign unused_inputs = ^{flash_be_i, flash_wdata_i, flash_offset[31:ADDR_WIDTH]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flash_gnt_o = 1'b0;
        case (state_q)
            IDLE: begin
                flash_gnt_o = flash_req_i;
                if (flash_req_i) begin
                    state_d = flash_we_i ? DONE : CMD;
                end
            end
            CMD:  if (period_end && bit_cnt_q == 6'd7)  state_d = ADDR;
            ADDR: if (period_end && bit_cnt_q == 6'd31) state_d = DATA;
            DATA: if (period_end && bit_cnt_q == 6'd63) state_d = DONE;
            DONE: state_d = is_write_q ? IDLE : GAP;
            GAP:  if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SCK phase, bit position and shift registers; the last MISO sample also
    // byte-swaps into rdata so the first flash byte lands in rdata[7:0].
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            sck_q      <= 1'b0;
            is_write_q <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            rdata_q    <= '0;
        end else begin
            gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + 1'b1 : '0;
            if (accept) begin
                div_cnt_q  <= '0;
                bit_cnt_q  <= '0;
                sck_q      <= 1'b0;
                is_write_q <= flash_we_i;
                tx_q       <= {8'h03, frame_addr};
                if (flash_we_i) begin
                    rdata_q <= '0;
                end
            end else if (shifting) begin
                if (div_last) begin
                    div_cnt_q <= '0;
                    sck_q     <= ~sck_q;
                    if (sck_q) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        tx_q      <= {tx_q[30:0], 1'b0};
                    end
                end else begin
                    div_cnt_q <= div_cnt_q + 1'b1;
                end
                if (sample) begin
                    rx_q <= rx_next;
                    if (bit_cnt_q == 6'd63) begin
                        rdata_q <= {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
                    end
                end
            end
        end
    end

    assign spi_csb_o       = ~shifting;
    assign spi_sck_o       = shifting && sck_q;
    assign spi_mosi_o      = ((state_q == CMD) || (state_q == ADDR)) && tx_q[31];
    assign flash_rvalid_o  = (state_q == DONE);
    assign illegal_write_o = (state_q == DONE) && is_write_q;
    assign flash_rdata_o   = rdata_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_obi_spiflash_responder.sv
// Self-checking bench for obi_spiflash_responder: SPI flash model plus a
// scoreboard of expected OBI responses checked whenever rvalid fires.

module tb_obi_spiflash_responder;

    localparam int CLK_DIV = 2;
    localparam int LAT     = 1 + 128 * CLK_DIV;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flash_req;
    logic        flash_gnt;
    logic [31:0] flash_addr;
    logic        flash_we;
    logic [3:0]  flash_be;
    logic [31:0] flash_wdata;
    logic        flash_rvalid;
    logic [31:0] flash_rdata;
    logic        spi_sck;
    logic        spi_csb;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;
    logic        busy;
    logic        illegal_write;

    int    cyc = 0;
    int    total_cnt = 0;
    int    pass_cnt = 0;
    resp_t exp_q[$];

    logic [31:0] cap_word = '0;
    int          bit_n = 0;
    logic [7:0]  fdata [4];

    obi_spiflash_responder #(
        .FLASH_BASE_ADDR(32'h2000_0000),
        .ADDR_WIDTH     (24),
        .CLK_DIV        (CLK_DIV)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flash_req_i    (flash_req),
        .flash_gnt_o    (flash_gnt),
        .flash_addr_i   (flash_addr),
        .flash_we_i     (flash_we),
        .flash_be_i     (flash_be),
        .flash_wdata_i  (flash_wdata),
        .flash_rvalid_o (flash_rvalid),
        .flash_rdata_o  (flash_rdata),
        .spi_sck_o      (spi_sck),
        .spi_csb_o      (spi_csb),
        .spi_mosi_o     (spi_mosi),
        .spi_miso_i     (spi_miso),
        .busy_o         (busy),
        .illegal_write_o(illegal_write)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mode-0 flash: capture command+address on rising SCK, shift data out on falling SCK.
    always @(posedge spi_sck or posedge spi_csb) begin
        if (spi_csb) begin
            bit_n = 0;
        end else begin
            if (bit_n < 32) cap_word = {cap_word[30:0], spi_mosi};
            bit_n = bit_n + 1;
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_csb && bit_n >= 32 && bit_n < 64) begin
            spi_miso = fdata[(bit_n - 32) / 8][7 - ((bit_n - 32) % 8)];
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n && flash_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL unexpected_rvalid: got rvalid=1 at cycle %0d, required no response", cyc);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                total_cnt++;
                if (flash_rdata !== e.rdata)
                    $display("[TB] FAIL rdata: got %h required %h", flash_rdata, e.rdata);
                else
                    pass_cnt++;
                total_cnt++;
                if (illegal_write !== e.illegal)
                    $display("[TB] FAIL illegal_write: got %b required %b", illegal_write, e.illegal);
                else
                    pass_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic start_read(input logic [31:0] addr, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input bit expect_resp);
        resp_t e;
        fdata[0] = b0; fdata[1] = b1; fdata[2] = b2; fdata[3] = b3;
        if (expect_resp) begin
            e.rdata   = {b3, b2, b1, b0};
            e.illegal = 1'b0;
            exp_q.push_back(e);
        end
        flash_we   = 1'b0;
        flash_addr = addr;
        flash_req  = 1'b1;
    endtask

    task automatic wait_grant(output int t);
        int n = 0;
        #1;
        while (flash_gnt !== 1'b1 && n < 600) begin
            @(negedge clk); #2;
            n++;
        end
        t = cyc;
        total_cnt++;
        if (n >= 600) $display("[TB] FAIL grant_timeout: got gnt=%b required 1", flash_gnt);
        else pass_cnt++;
    endtask

    task automatic finish_read(input int t_acc, input logic [23:0] exp_addr, input bit keep_req,
                               output int t_rv);
        int n = 0;
        @(negedge clk); #2;
        total_cnt++;
        if (spi_csb !== 1'b0) $display("[TB] FAIL csb_fall: got csb=%b at T+1 required 0", spi_csb);
        else pass_cnt++;
        if (!keep_req) flash_req = 1'b0;
        while (flash_rvalid !== 1'b1 && n < 600) begin
            @(negedge clk); #2;
            n++;
        end
        t_rv = cyc;
        total_cnt++;
        if (t_rv - t_acc != LAT) $display("[TB] FAIL read_latency: got %0d required %0d", t_rv - t_acc, LAT);
        else pass_cnt++;
        total_cnt++;
        if (spi_csb !== 1'b1 || spi_sck !== 1'b0)
            $display("[TB] FAIL done_pins: got csb=%b sck=%b required csb=1 sck=0", spi_csb, spi_sck);
        else pass_cnt++;
        total_cnt++;
        if (cap_word !== {8'h03, exp_addr})
            $display("[TB] FAIL spi_cmd_addr: got %h required %h", cap_word, {8'h03, exp_addr});
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flash_req = 1'b0; flash_we = 1'b0;
        flash_addr = '0; flash_be = 4'hF; flash_wdata = '0;
        repeat (3) @(negedge clk);
        #2;
        total_cnt++;
        if (spi_csb !== 1'b1 || spi_sck !== 1'b0 || spi_mosi !== 1'b0)
            $display("[TB] FAIL reset_spi: got csb=%b sck=%b mosi=%b required 1 0 0", spi_csb, spi_sck, spi_mosi);
        else pass_cnt++;
        total_cnt++;
        if (flash_gnt !== 1'b0 || flash_rvalid !== 1'b0 || busy !== 1'b0 || illegal_write !== 1'b0)
            $display("[TB] FAIL reset_ctrl: got gnt=%b rvalid=%b busy=%b ill=%b required all 0",
                     flash_gnt, flash_rvalid, busy, illegal_write);
        else pass_cnt++;
        total_cnt++;
        if (flash_rdata !== 32'h0) $display("[TB] FAIL reset_rdata: got %h required 0", flash_rdata);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #2;
    endtask

    task automatic test_read(input logic [31:0] addr, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input logic [23:0] exp_addr);
        int t_acc, t_rv;
        start_read(addr, b0, b1, b2, b3, 1'b1);
        wait_grant(t_acc);
        finish_read(t_acc, exp_addr, 1'b0, t_rv);
        @(negedge clk); #2;
        total_cnt++;
        if (flash_rdata !== {b3, b2, b1, b0})
            $display("[TB] FAIL rdata_hold: got %h required %h", flash_rdata, {b3, b2, b1, b0});
        else pass_cnt++;
        repeat (2 * CLK_DIV) @(negedge clk);
        #2;
    endtask

    task automatic test_write();
        int t_acc;
        int bad = 0;
        resp_t e;
        e.rdata = 32'h0; e.illegal = 1'b1;
        exp_q.push_back(e);
        flash_we = 1'b1; flash_addr = 32'h2000_0000; flash_wdata = 32'hDEAD_BEEF; flash_req = 1'b1;
        wait_grant(t_acc);
        if (spi_csb !== 1'b1 || spi_sck !== 1'b0 || spi_mosi !== 1'b0) bad++;
        @(negedge clk); #2;
        flash_req = 1'b0; flash_we = 1'b0;
        total_cnt++;
        if (flash_rvalid !== 1'b1 || cyc != t_acc + 1)
            $display("[TB] FAIL write_rvalid: got rvalid=%b at T+%0d required 1 at T+1", flash_rvalid, cyc - t_acc);
        else pass_cnt++;
        if (spi_csb !== 1'b1 || spi_sck !== 1'b0 || spi_mosi !== 1'b0) bad++;
        @(negedge clk); #2;
        if (spi_csb !== 1'b1 || spi_sck !== 1'b0 || spi_mosi !== 1'b0) bad++;
        total_cnt++;
        if (bad != 0) $display("[TB] FAIL write_spi_idle: got %0d active samples required 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (flash_rvalid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL write_return: got rvalid=%b busy=%b required 0 0", flash_rvalid, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int t1, rv1, t2, rv2;
        int n = 0;
        int csb_high = 1;
        start_read(32'h2000_0040, 8'h01, 8'h23, 8'h45, 8'h67, 1'b1);
        wait_grant(t1);
        finish_read(t1, 24'h000040, 1'b1, rv1);
        start_read(32'h2000_0080, 8'h89, 8'hAB, 8'hCD, 8'hEF, 1'b1);
        while (n < 40) begin
            @(negedge clk); #2;
            n++;
            if (spi_csb === 1'b1) csb_high++;
            if (flash_gnt === 1'b1) break;
        end
        t2 = cyc;
        total_cnt++;
        if (t2 - rv1 != 2 * CLK_DIV)
            $display("[TB] FAIL b2b_grant: got %0d cycles after rvalid required %0d", t2 - rv1, 2 * CLK_DIV);
        else pass_cnt++;
        total_cnt++;
        if (csb_high < 2 * CLK_DIV)
            $display("[TB] FAIL b2b_deselect: got %0d csb-high cycles required >= %0d", csb_high, 2 * CLK_DIV);
        else pass_cnt++;
        finish_read(t2, 24'h000080, 1'b0, rv2);
        repeat (2 * CLK_DIV + 1) @(negedge clk);
        #2;
    endtask

    task automatic test_reset_abort();
        int t_acc;
        int n = 0;
        int stray = 0;
        start_read(32'h2000_0200, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 1'b0);
        wait_grant(t_acc);
        @(negedge clk); #2;
        flash_req = 1'b0;
        while (bit_n < 28 && n < 600) begin
            @(negedge clk); #2;
            n++;
        end
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (spi_csb !== 1'b1 || spi_sck !== 1'b0 || busy !== 1'b0 || bit_n != 0)
            $display("[TB] FAIL abort_pins: got csb=%b sck=%b busy=%b bit=%0d required 1 0 0 0",
                     spi_csb, spi_sck, busy, bit_n);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) begin
            @(negedge clk); #2;
            if (flash_rvalid !== 1'b0) stray++;
        end
        total_cnt++;
        if (stray != 0) $display("[TB] FAIL abort_no_rvalid: got %0d rvalid cycles required 0", stray);
        else pass_cnt++;
    endtask

    initial begin
        $display("[TB] start, CLK_DIV=%0d", CLK_DIV);
        test_reset();
        test_read(32'h2000_0104, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 24'h000104);
        test_read(32'h20FF_FFFE, 8'h11, 8'h22, 8'h33, 8'h44, 24'hFFFFFC);
        test_write();
        test_back_to_back();
        test_reset_abort();
        test_read(32'h2012_3457, 8'($urandom_range(0, 255)), 8'h00, 8'hFF, 8'h96, 24'h123454);
        test_read(32'h1FFF_FFFC, 8'h80, 8'h01, 8'h7E, 8'hE7, 24'hFFFFFC);
        total_cnt++;
        if (exp_q.size() != 0) $display("[TB] FAIL missing_responses: got %0d pending required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
